// File: rtl/rshift_iter.sv
// Iterative 32-bit logical/arithmetic right shifter: one barrel stage (16/8/4/2/1)
// per clock under a start/busy/done handshake; every operation takes five stages.
module rshift_iter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        S16,
        S8,
        S4,
        S2,
        S1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  amt_q, amt_d;
    logic        fill_q, fill_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Shift by a fixed stage width when enabled; vacated bits take the captured fill,
    // never the current work[31].
    function automatic logic [31:0] stage_shift(input logic [31:0] v,
                                                input logic        en,
                                                input logic        f,
                                                input logic [4:0]  n);
        logic [31:0] fill_mask;
        fill_mask = f ? ~(32'hFFFF_FFFF >> n) : 32'h0000_0000;
        return en ? ((v >> n) | fill_mask) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        amt_d    = amt_q;
        fill_d   = fill_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = A;
                    amt_d   = shamt;
                    fill_d  = A[31] & arith;
                    busy_d  = 1'b1;
                    state_d = S16;
                end
            end
            S16: begin
                work_d  = stage_shift(work_q, amt_q[4], fill_q, 5'd16);
                state_d = S8;
            end
            S8: begin
                work_d  = stage_shift(work_q, amt_q[3], fill_q, 5'd8);
                state_d = S4;
            end
            S4: begin
                work_d  = stage_shift(work_q, amt_q[2], fill_q, 5'd4);
                state_d = S2;
            end
            S2: begin
                work_d  = stage_shift(work_q, amt_q[1], fill_q, 5'd2);
                state_d = S1;
            end
            S1: begin
                work_d   = stage_shift(work_q, amt_q[0], fill_q, 5'd1);
                result_d = stage_shift(work_q, amt_q[0], fill_q, 5'd1);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            amt_q    <= '0;
            fill_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            amt_q    <= amt_d;
            fill_q   <= fill_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rshift_iter.sv
// Scoreboard bench for rshift_iter: drivers push expected results and completion
// cycles; a negedge monitor pops one entry per done pulse and compares.
module tb_rshift_iter;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rshift_iter dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .A      (A),
        .shamt  (shamt),
        .arith  (arith),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                          input logic ar);
        logic signed [31:0] sa;
        sa = a;
        if (ar) return sa >>> s;
        return a >> s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: each done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h required=no_done", result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("latency", cyc, mon_e.cyc);
                chk("busy_at_done", {31'b0, busy}, 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clock);
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Issues one operation at a negedge where the unit is idle; returns at the
    // negedge after the accepting edge with start already dropped.
    task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic ar,
                         input logic [31:0] expv);
        wait_idle();
        A     = a;
        shamt = s;
        arith = ar;
        start = 1'b1;
        sb.push_back('{res: expv, cyc: cyc + 6});
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rs;
        logic        rar;
        int unsigned expc;
        int unsigned n;

        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        shamt   = '0;
        arith   = 1'b0;
        #12;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // SRL 31 with busy window
        issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            chk("busy_window", {31'b0, busy}, 32'h1);
            @(negedge clock);
        end
        chk("busy_end", {31'b0, busy}, 32'h0);
        chk("done_at_e5", {31'b0, done}, 32'h1);

        issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        issue(32'hF0F0_1234, 5'd4, 1'b1, 32'hFF0F_0123);
        issue(32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        issue(32'h8765_4321, 5'd16, 1'b0, 32'h0000_8765);
        issue(32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765);
        drain();

        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 32; s++) begin
                issue(32'h8765_4321, 5'(s), 1'(m), model(32'h8765_4321, 5'(s), 1'(m)));
            end
        end
        drain();

        // start pulsed while busy must be ignored
        issue(32'h0000_FF00, 5'd8, 1'b0, 32'h0000_00FF);
        @(negedge clock);
        A     = 32'hFFFF_FFFF;
        shamt = 5'd1;
        arith = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clock);

        // reset in the middle of an operation
        issue(32'h1234_5678, 5'd3, 1'b0, 32'h0246_8ACF);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_result", result, 32'h0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        issue(32'hCAFE_0000, 5'd12, 1'b1, 32'hFFFC_AFE0);
        drain();

        // back-to-back with start held high
        wait_idle();
        expc  = cyc + 6;
        A     = 32'hA5A5_A5A5;
        shamt = 5'd5;
        arith = 1'b1;
        start = 1'b1;
        sb.push_back('{res: model(A, shamt, arith), cyc: expc});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("b2b_busy", {31'b0, busy}, 32'h1);
            if (k < 6) begin
                A     = (k % 2 == 1) ? 32'h5A5A_5A5A ^ $urandom : 32'hA5A5_A5A5 ^ $urandom;
                shamt = 5'($urandom_range(0, 31));
                arith = 1'($urandom_range(0, 1));
                expc  = expc + 6;
                sb.push_back('{res: model(A, shamt, arith), cyc: expc});
            end else begin
                start = 1'b0;
            end
            n = 0;
            while (busy && n < 10) begin
                @(negedge clock);
                n++;
            end
        end
        drain();

        // randomized operations
        for (int r = 0; r < 40; r++) begin
            ra  = $urandom;
            rs  = 5'($urandom_range(0, 31));
            rar = 1'($urandom_range(0, 1));
            issue(ra, rs, rar, model(ra, rs, rar));
        end
        drain();
        repeat (8) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
